// File: rtl/seven_seg_decoder.sv
// Seven-segment bus decoder: synchronise, debounce, decode to hex, emit through a 1-entry valid/ready register.
// Optional decimal point support is enabled by defining SEG7_DEC_DP_EN.
module seven_seg_decoder #(
    parameter bit INVERT        = 1'b1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
`ifdef SEG7_DEC_DP_EN
    input  logic       seg_dp,
    output logic       out_dp,
`endif
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_value,
    output logic       out_error,
    output logic       blank,
    output logic       overflow
);

`ifdef SEG7_DEC_DP_EN
    localparam int W = 8;
    logic [W-1:0] raw;
    assign raw = {seg_dp, seg_in};
`else
    localparam int W = 7;
    logic [W-1:0] raw;
    assign raw = seg_in;
`endif

    localparam logic [W-1:0] IDLE_RAW = INVERT ? {W{1'b1}} : {W{1'b0}};
    localparam logic [7:0]   CNT_MAX  = 8'(STABLE_CYCLES);

    logic [W-1:0] s1, s2, p, p_prev;
    logic [7:0]   cnt;
    logic         armed;
    logic         fire, is_blank, evt;
    logic [4:0]   dec;

    assign p = INVERT ? ~s2 : s2;

    // Returns {error, value}; unknown patterns decode to error with value 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // p_prev holds the pattern whose stability cnt is measuring, so it is what gets decoded.
    always_comb begin
        fire     = armed && (cnt == CNT_MAX);
        is_blank = (p_prev == '0);
        evt      = fire && !is_blank;
        dec      = decode(p_prev[6:0]);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= IDLE_RAW;
            s2     <= IDLE_RAW;
            p_prev <= '0;
            cnt    <= '0;
            armed  <= 1'b1;
        end else begin
            s1     <= raw;
            s2     <= s1;
            p_prev <= p;
            if (p != p_prev) begin
                cnt   <= 8'd1;
                armed <= 1'b1;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 8'd1;
                if (fire)
                    armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_value <= 4'h0;
            out_error <= 1'b0;
            blank     <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (fire)
                blank <= is_blank;
            if (evt) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_value <= dec[4] ? 4'h0 : dec[3:0];
                    out_error <= dec[4];
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SEG7_DEC_DP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_dp <= 1'b0;
        else if (evt && (!out_valid || out_ready))
            out_dp <= p_prev[7];
    end
`endif

endmodule
